fru_pla_cfg_ctrl: RTL and testbench
===================================

Name: fru_pla_cfg_ctrl

Overview:
Configuration controller for the segmented FRU PLA. It accepts a packet of per-output configuration entries over a valid/ready stream and assembles them in shadow registers. On a complete, well-formed packet it atomically commits all entries to the active RegMux / RegMintermORSelect buses that drive the PLA. Partial or oversized packets are rejected, so the PLA never sees a half-written configuration.

Parameters:
INPUT_SIZE, 2, number of trigger inputs of the PLA; MUX_W = $clog2(INPUT_SIZE)
OUTPUT_SIZE, 4, number of PLA units, i.e. entries per packet
SEGMENT_SIZE, 2, PLA segment size; MT_W = 2**SEGMENT_SIZE; ENTRY_W = MUX_W + MT_W

Ports:
clk  input  1  block clock
rst_n  input  1  asynchronous active-low reset
CfgValid  input  1  beat valid
CfgReady  output  1  beat ready; a beat is accepted when CfgValid && CfgReady
CfgData  input  ENTRY_W  entry payload; [ENTRY_W-1:MT_W] = mux select, [MT_W-1:0] = minterm OR select
CfgLast  input  1  marks the final beat of a packet
ErrClr  input  1  clears CfgErr
RegMux  output  OUTPUT_SIZE x MUX_W  active mux config, packed; entry i at [i]
RegMintermORSelect  output  OUTPUT_SIZE x MT_W  active minterm config, packed
CfgDone  output  1  one-cycle pulse when a new configuration becomes active
CfgErr  output  1  sticky packet-error flag
CfgBusy  output  1  high while in any state other than IDLE

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, ptr = 0.
  - All shadow and active registers = 0.
  - CfgDone = 0, CfgErr = 0.
  - CfgReady is low during reset and high in IDLE after release.
- Beat i of a packet writes shadow[i]. ptr counts beats and is $clog2(OUTPUT_SIZE+1) bits wide.
- States:
  - IDLE: CfgReady = 1. An accepted beat writes shadow[0] and sets ptr = 1.
    - With CfgLast: go to COMMIT if OUTPUT_SIZE == 1, else ERR_END.
    - Without CfgLast: go to LOAD.
  - LOAD: CfgReady = 1. An accepted beat writes shadow[ptr] and increments ptr.
    - CfgLast with ptr == OUTPUT_SIZE-1: go to COMMIT.
    - CfgLast with ptr < OUTPUT_SIZE-1 (short packet): go to ERR_END.
    - No CfgLast with ptr == OUTPUT_SIZE-1: go to DRAIN, because the next beat would overflow.
  - DRAIN: CfgReady = 1. Accepted beats are discarded and shadow is not written.
    - The first accepted beat with CfgLast goes to ERR_END.
  - ERR_END: one cycle, CfgReady = 0. Sets CfgErr = 1, shadow is discarded, active is unchanged, ptr = 0, go to IDLE.
  - COMMIT: one cycle, CfgReady = 0. At the clock edge: active <= all shadow entries in parallel, CfgDone <= 1, ptr = 0, go to IDLE.
- Latency: last beat accepted in cycle N, COMMIT in cycle N+1, new RegMux/RegMintermORSelect and CfgDone = 1 in cycle N+2. CfgDone is low otherwise.
- Active outputs are registered and change only at COMMIT. There are no glitches or partial updates.
- CfgValid low in LOAD or DRAIN holds state with no timeout. The stream may stall indefinitely.
- CfgErr:
  - Sticky; cleared by ErrClr at the next edge.
  - If ErrClr coincides with ERR_END, the set wins and CfgErr stays 1.
  - CfgErr does not block new packets.
- A mux value >= INPUT_SIZE is passed through unchecked; range checking is the programmer's responsibility.
- Reset asserted mid-packet: all state returns to reset values immediately, the active config goes to 0, and no CfgDone is issued.

Optional Feature:
FRU_PLA_CFG_LOCK_EN
- When defined:
  - Adds input Lock (1 bit) and output CfgLocked (1 bit).
  - Lock = 1 in IDLE sets CfgLocked; it is cleared only by rst_n.
  - While locked, every packet is routed to DRAIN and then ERR_END. Active config is never changed and CfgErr is set per rejected packet.
  - Lock asserted mid-packet takes effect after the current packet completes or errors.
- When undefined: no Lock or CfgLocked ports, and the behaviour is exactly as above.

Test Plan:
- Reset then idle: RegMux = 0, RegMintermORSelect = 0, CfgReady = 1, CfgErr = 0, CfgDone = 0.
- Valid packet (defaults, ENTRY_W = 5): beats 5'h01, 5'h12, 5'h04, 5'h18 with Last on the 4th -> 2 cycles later RegMux = {1,0,1,0} and RegMintermORSelect = {8,4,2,1}, entries listed [3]..[0]; CfgDone pulses for 1 cycle.
- Short packet: 2 beats, Last on the 2nd -> CfgErr = 1, active unchanged, no CfgDone. ErrClr = 1 then clears CfgErr.
- Oversized packet: 6 beats, Last on the 6th -> beats 5 and 6 accepted and discarded, CfgErr = 1, active keeps the prior config.
- Stalled stream: 2 beats, CfgValid low for 50 cycles, then 2 beats with Last -> commit as normal. Separately, rst_n pulsed during the stall -> active = 0 and state = IDLE.
- With FRU_PLA_CFG_LOCK_EN: commit a config, pulse Lock, then send a valid packet -> CfgLocked = 1, CfgErr = 1, active unchanged.

Source files
------------

// File: rtl/fru_pla_cfg_ctrl.sv
// FRU PLA configuration controller: assembles a packet of entries in shadow
// registers and commits them atomically. Optional lock: FRU_PLA_CFG_LOCK_EN.
//   state   | meaning
//   IDLE    | waiting for first beat of a packet
//   LOAD    | collecting beats into shadow
//   DRAIN   | packet overflowed (or locked), discarding beats until Last
//   ERR_END | reject packet, set CfgErr
//   COMMIT  | copy shadow to active, pulse CfgDone
module fru_pla_cfg_ctrl #(
  parameter int INPUT_SIZE   = 2,
  parameter int OUTPUT_SIZE  = 4,
  parameter int SEGMENT_SIZE = 2,
  localparam int MUX_W   = $clog2(INPUT_SIZE),
  localparam int MT_W    = 2**SEGMENT_SIZE,
  localparam int ENTRY_W = MUX_W + MT_W
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          CfgValid,
  output logic                          CfgReady,
  input  logic [ENTRY_W-1:0]            CfgData,
  input  logic                          CfgLast,
  input  logic                          ErrClr,
`ifdef FRU_PLA_CFG_LOCK_EN
  input  logic                          Lock,
  output logic                          CfgLocked,
`endif
  output logic [OUTPUT_SIZE*MUX_W-1:0]  RegMux,
  output logic [OUTPUT_SIZE*MT_W-1:0]   RegMintermORSelect,
  output logic                          CfgDone,
  output logic                          CfgErr,
  output logic                          CfgBusy
);

  localparam int PTR_W = $clog2(OUTPUT_SIZE + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTPUT_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_ERR_END, S_COMMIT
  } state_e;

  state_e                                state_q, state_d;
  logic [PTR_W-1:0]                      ptr_q, ptr_d;
  logic [OUTPUT_SIZE-1:0][ENTRY_W-1:0]   shadow_q, shadow_d;
  logic [OUTPUT_SIZE-1:0][MUX_W-1:0]     mux_q, mux_d;
  logic [OUTPUT_SIZE-1:0][MT_W-1:0]      mt_q, mt_d;
  logic                                  done_q, done_d;
  logic                                  err_q, err_d;
  logic                                  locked_q, locked_d;
  logic                                  rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      shadow_q <= '0;
      mux_q    <= '0;
      mt_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      shadow_q <= shadow_d;
      mux_q    <= mux_d;
      mt_q     <= mt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    shadow_d = shadow_q;
    mux_d    = mux_q;
    mt_d     = mt_q;
    done_d   = 1'b0;
    err_d    = err_q & ~ErrClr;
    locked_d = locked_q;
    rdy      = 1'b0;
`ifdef FRU_PLA_CFG_LOCK_EN
    if (state_q == S_IDLE && Lock) locked_d = 1'b1;
`endif
    case (state_q)
      S_IDLE: begin
        rdy = 1'b1;
        if (CfgValid) begin
          if (locked_q) begin
            state_d = CfgLast ? S_ERR_END : S_DRAIN;
          end else begin
            shadow_d[0] = CfgData;
            ptr_d       = PTR_W'(1);
            if (CfgLast)                    state_d = (OUTPUT_SIZE == 1) ? S_COMMIT : S_ERR_END;
            else if (LAST_PTR == '0)        state_d = S_DRAIN;
            else                            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        rdy = 1'b1;
        if (CfgValid) begin
          for (int i = 0; i < OUTPUT_SIZE; i++)
            if (ptr_q == PTR_W'(i)) shadow_d[i] = CfgData;
          ptr_d = ptr_q + PTR_W'(1);
          if (CfgLast)                 state_d = (ptr_q == LAST_PTR) ? S_COMMIT : S_ERR_END;
          else if (ptr_q == LAST_PTR)  state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        rdy = 1'b1;
        if (CfgValid && CfgLast) state_d = S_ERR_END;
      end
      S_ERR_END: begin
        err_d    = 1'b1;
        shadow_d = '0;
        ptr_d    = '0;
        state_d  = S_IDLE;
      end
      S_COMMIT: begin
        for (int i = 0; i < OUTPUT_SIZE; i++) begin
          mux_d[i] = shadow_q[i][ENTRY_W-1:MT_W];
          mt_d[i]  = shadow_q[i][MT_W-1:0];
        end
        done_d  = 1'b1;
        ptr_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ready is forced low while reset is held even though the state is IDLE.
  assign CfgReady           = rdy & rst_n;
  assign RegMux             = mux_q;
  assign RegMintermORSelect = mt_q;
  assign CfgDone            = done_q;
  assign CfgErr             = err_q;
  assign CfgBusy            = (state_q != S_IDLE);
`ifdef FRU_PLA_CFG_LOCK_EN
  assign CfgLocked          = locked_q;
`endif

endmodule

// File: tb/tb_fru_pla_cfg_ctrl.sv
// Directed self-checking bench for fru_pla_cfg_ctrl (default build, lock disabled).
module tb_fru_pla_cfg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        CfgValid = 1'b0;
  logic        CfgReady;
  logic [4:0]  CfgData = '0;
  logic        CfgLast = 1'b0;
  logic        ErrClr = 1'b0;
  logic [3:0]  RegMux;
  logic [15:0] RegMintermORSelect;
  logic        CfgDone;
  logic        CfgErr;
  logic        CfgBusy;

  int n_vec = 0;
  int n_err = 0;

  fru_pla_cfg_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .CfgValid           (CfgValid),
    .CfgReady           (CfgReady),
    .CfgData            (CfgData),
    .CfgLast            (CfgLast),
    .ErrClr             (ErrClr),
    .RegMux             (RegMux),
    .RegMintermORSelect (RegMintermORSelect),
    .CfgDone            (CfgDone),
    .CfgErr             (CfgErr),
    .CfgBusy            (CfgBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [4:0] d, input logic l);
    CfgValid = 1'b1;
    CfgData  = d;
    CfgLast  = l;
    step();
    CfgValid = 1'b0;
    CfgLast  = 1'b0;
    CfgData  = '0;
  endtask

  initial begin
    // reset held
    #12;
    chk("rst_ready", 32'(CfgReady), 0);
    chk("rst_mux", 32'(RegMux), 0);
    chk("rst_mt", 32'(RegMintermORSelect), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(CfgReady), 1);
    chk("idle_err", 32'(CfgErr), 0);
    chk("idle_done", 32'(CfgDone), 0);
    chk("idle_busy", 32'(CfgBusy), 0);

    // valid packet
    beat(5'h01, 1'b0);
    chk("load_busy", 32'(CfgBusy), 1);
    beat(5'h12, 1'b0);
    beat(5'h04, 1'b0);
    beat(5'h18, 1'b1);
    chk("commit_ready", 32'(CfgReady), 0);
    chk("commit_done_early", 32'(CfgDone), 0);
    chk("commit_mux_early", 32'(RegMux), 0);
    step();
    chk("ok_done", 32'(CfgDone), 1);
    chk("ok_mux", 32'(RegMux), 32'hA);
    chk("ok_mt", 32'(RegMintermORSelect), 32'h8421);
    chk("ok_busy", 32'(CfgBusy), 0);
    step();
    chk("ok_done_pulse", 32'(CfgDone), 0);

    // short packet
    beat(5'h05, 1'b0);
    beat(5'h1F, 1'b1);
    chk("short_errend_ready", 32'(CfgReady), 0);
    step();
    chk("short_err", 32'(CfgErr), 1);
    chk("short_done", 32'(CfgDone), 0);
    chk("short_mux", 32'(RegMux), 32'hA);
    chk("short_mt", 32'(RegMintermORSelect), 32'h8421);
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    chk("errclr", 32'(CfgErr), 0);

    // oversized packet, ErrClr coinciding with ERR_END
    beat(5'h0F, 1'b0);
    beat(5'h0F, 1'b0);
    beat(5'h0F, 1'b0);
    beat(5'h0F, 1'b0);
    chk("drain_ready", 32'(CfgReady), 1);
    chk("drain_busy", 32'(CfgBusy), 1);
    beat(5'h1F, 1'b0);
    beat(5'h1F, 1'b1);
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    chk("over_err_set_wins", 32'(CfgErr), 1);
    chk("over_done", 32'(CfgDone), 0);
    chk("over_mux", 32'(RegMux), 32'hA);
    chk("over_mt", 32'(RegMintermORSelect), 32'h8421);
    ErrClr = 1'b1;
    step();
    ErrClr = 1'b0;
    chk("errclr2", 32'(CfgErr), 0);

    // stalled stream commits normally
    beat(5'h03, 1'b0);
    beat(5'h1C, 1'b0);
    repeat (50) step();
    chk("stall_busy", 32'(CfgBusy), 1);
    chk("stall_ready", 32'(CfgReady), 1);
    chk("stall_mux_hold", 32'(RegMux), 32'hA);
    beat(5'h16, 1'b0);
    beat(5'h09, 1'b1);
    step();
    chk("stall_done", 32'(CfgDone), 1);
    chk("stall_mux", 32'(RegMux), 32'h6);
    chk("stall_mt", 32'(RegMintermORSelect), 32'h96C3);
    chk("stall_err", 32'(CfgErr), 0);

    // reset during a stall
    beat(5'h1F, 1'b0);
    beat(5'h1F, 1'b0);
    repeat (10) step();
    rst_n = 1'b0;
    #2;
    chk("midrst_mux", 32'(RegMux), 0);
    chk("midrst_mt", 32'(RegMintermORSelect), 0);
    chk("midrst_busy", 32'(CfgBusy), 0);
    chk("midrst_ready", 32'(CfgReady), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("postrst_ready", 32'(CfgReady), 1);
    chk("postrst_done", 32'(CfgDone), 0);
    beat(5'h1F, 1'b0);
    beat(5'h00, 1'b0);
    beat(5'h00, 1'b0);
    beat(5'h00, 1'b1);
    step();
    chk("postrst_commit_done", 32'(CfgDone), 1);
    chk("postrst_mux", 32'(RegMux), 32'h1);
    chk("postrst_mt", 32'(RegMintermORSelect), 32'h000F);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
